// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI mode, bit-index and FSM state definitions.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DEFAULT_DATA_W = 16;

    localparam logic [1:0] SPI_MODE0 = 2'd0;
    localparam logic [1:0] SPI_MODE1 = 2'd1;
    localparam logic [1:0] SPI_MODE2 = 2'd2;
    localparam logic [1:0] SPI_MODE3 = 2'd3;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : User-side and SPI pin bundle for spi_slave.
//            SPI_SLAVE_ERR_EN adds frame_err / err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [1:0]        spi_mode;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              spi_csn;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
`ifdef SPI_SLAVE_ERR_EN
    logic              frame_err;
    logic [7:0]        err_cnt;
`endif

    modport slave (
        input  spi_mode, tx_data, spi_csn, spi_clk, spi_mosi,
        output tx_load, rx_data, rx_valid, busy, spi_miso, spi_miso_oe
`ifdef SPI_SLAVE_ERR_EN
        , output frame_err, output err_cnt
`endif
    );

    modport master (
        output spi_mode, tx_data, spi_csn, spi_clk, spi_mosi,
        input  tx_load, rx_data, rx_valid, busy, spi_miso, spi_miso_oe
`ifdef SPI_SLAVE_ERR_EN
        , input frame_err, input err_cnt
`endif
    );

endinterface : spi_slave_if
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer with registered rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STG = 2,
    parameter logic RST_VAL  = 1'b1
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_dly;
    logic                r_rise;
    logic                r_fall;

    // Level is the delayed copy so it lines up with the registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STG{RST_VAL}};
            r_dly  <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_d};
            r_dly  <= r_sync[SYNC_STG-1];
            r_rise <= r_sync[SYNC_STG-1] & ~r_dly;
            r_fall <= ~r_sync[SYNC_STG-1] & r_dly;
        end
    end

    assign o_level = r_dly;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Oversampling SPI responder, modes 0-3, MSB first, fixed word.
//            Define SPI_SLAVE_ERR_EN for frame_err / err_cnt reporting.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int SYNC_STG = 2
) (
    input  wire          sys_clk,
    input  wire          sys_rst,
    spi_slave_if.slave   bus
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  c_LAST   = CNT_W'(DATA_W - 1);
    localparam int                SETTLE_W = $clog2(SYNC_STG + 2);
    localparam logic [SETTLE_W-1:0] c_SETTLE = SETTLE_W'(SYNC_STG + 1);

    logic w_csn_level, w_csn_rise, w_csn_fall;
    logic w_clk_rise, w_clk_fall, w_clk_level_unused;
    logic w_mosi_level, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_csn (
        .clk(sys_clk), .rst(sys_rst), .i_d(bus.spi_csn),
        .o_level(w_csn_level), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_clk (
        .clk(sys_clk), .rst(sys_rst), .i_d(bus.spi_clk),
        .o_level(w_clk_level_unused), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
    );

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_mosi (
        .clk(sys_clk), .rst(sys_rst), .i_d(bus.spi_mosi),
        .o_level(w_mosi_level), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    spi_state_t        r_state;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift_rx;
    logic [DATA_W-1:0] r_shift_tx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_load;
    logic              r_busy;
    logic              r_miso;
    logic              r_oe;
    logic [SETTLE_W-1:0] r_settle;
    logic              r_armed;
`ifdef SPI_SLAVE_ERR_EN
    logic              r_frame_err;
    logic [7:0]        r_err_cnt;
`endif

    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_shift;
    logic [DATA_W-1:0] w_rx_next;

    assign w_lead    = r_mode[CPOL_BIT] ? w_clk_fall : w_clk_rise;
    assign w_trail   = r_mode[CPOL_BIT] ? w_clk_rise : w_clk_fall;
    assign w_sample  = r_mode[CPHA_BIT] ? w_trail : w_lead;
    assign w_shift   = r_mode[CPHA_BIT] ? w_lead  : w_trail;
    assign w_rx_next = {r_shift_rx[DATA_W-2:0], w_mosi_level};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= SPI_MODE0;
            r_cnt      <= '0;
            r_shift_rx <= '0;
            r_shift_tx <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_busy     <= 1'b0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_settle   <= '0;
            r_armed    <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'h00;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            r_frame_err <= 1'b0;
`endif
            // The synchronizers come out of reset reading "csn high"; a csn
            // already held low would look like a fresh fall, so only arm once
            // the pipeline has flushed and csn is genuinely high.
            if (r_settle != c_SETTLE) begin
                r_settle <= r_settle + 1'b1;
            end else if (w_csn_level) begin
                r_armed <= 1'b1;
            end

            if ((r_state != ST_IDLE) && w_csn_rise) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_oe    <= 1'b0;
                r_miso  <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
                if (r_cnt != '0) begin
                    r_frame_err <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csn_fall && r_armed) begin
                            r_mode     <= bus.spi_mode;
                            r_tx_load  <= 1'b1;
                            r_shift_tx <= bus.tx_data;
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_oe       <= 1'b1;
                            r_state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (!r_mode[CPHA_BIT]) begin
                            r_miso     <= r_shift_tx[DATA_W-1];
                            r_shift_tx <= r_shift_tx << 1;
                        end
                        r_state <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (w_sample) begin
                            r_shift_rx <= w_rx_next;
                            if (r_cnt == c_LAST) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                                r_cnt      <= '0;
                                r_tx_load  <= 1'b1;
                                r_shift_tx <= bus.tx_data;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (w_shift) begin
                            // Reload at word end leaves the new MSB on top,
                            // so every shift edge simply emits the top bit.
                            r_miso     <= r_shift_tx[DATA_W-1];
                            r_shift_tx <= r_shift_tx << 1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_load     = r_tx_load;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.busy        = r_busy;
    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = r_oe;
`ifdef SPI_SLAVE_ERR_EN
    assign bus.frame_err   = r_frame_err;
    assign bus.err_cnt     = r_err_cnt;
`endif

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave with a bit-level SPI master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;
    import spi_pkg::*;

    localparam int DATA_W = DEFAULT_DATA_W;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    spi_slave_if #(.DATA_W(DATA_W)) bus ();

    spi_slave #(.DATA_W(DATA_W), .SYNC_STG(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    int n_tx_load = 0;
    int n_oe      = 0;
    int n_ferr    = 0;
    int tx_base   = 0;
    logic [DATA_W-1:0] tx_words [8];
    logic [DATA_W-1:0] rx_q [$];

    // Observer: collects received words, counts strobes, and presents the
    // next queued transmit word after every tx_load.
    always @(negedge sys_clk) begin
        int k;
        if (bus.tx_load === 1'b1) n_tx_load++;
        if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
        if (bus.spi_miso_oe === 1'b1) n_oe++;
`ifdef SPI_SLAVE_ERR_EN
        if (bus.frame_err === 1'b1) n_ferr++;
`endif
        k = n_tx_load - tx_base;
        if (k > 7) k = 7;
        if (k < 0) k = 0;
        bus.tx_data = tx_words[k];
    end

    task automatic new_tx(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                          input logic [DATA_W-1:0] w2);
        tx_words[0] = w0;
        tx_words[1] = w1;
        tx_words[2] = w2;
        for (int i = 3; i < 8; i++) tx_words[i] = DATA_W'($urandom);
        tx_base = n_tx_load;
        @(negedge sys_clk);
    endtask

    // Bit-level SPI master: drives mosi on the shift edge, captures miso on
    // the sample edge, optionally rewrites spi_mode at bit 4.
    task automatic xfer(input logic [1:0] mode, input logic [1:0] mid_mode,
                        input int nbits, input int half,
                        input logic [63:0] mosi_word, output logic [63:0] miso_word);
        logic cpol, cpha;
        cpol = mode[CPOL_BIT];
        cpha = mode[CPHA_BIT];
        miso_word = '0;
        bus.spi_mode = mode;
        bus.spi_clk  = cpol;
        repeat (8) @(negedge sys_clk);
        bus.spi_csn = 1'b0;
        if (!cpha) bus.spi_mosi = mosi_word[nbits-1];
        repeat (2 * half) @(negedge sys_clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == 4) bus.spi_mode = mid_mode;
            if (cpha) bus.spi_mosi = mosi_word[nbits-1-i];
            else      miso_word = {miso_word[62:0], bus.spi_miso};
            bus.spi_clk = ~cpol;
            repeat (half) @(negedge sys_clk);
            if (cpha) miso_word = {miso_word[62:0], bus.spi_miso};
            else if (i < nbits - 1) bus.spi_mosi = mosi_word[nbits-2-i];
            bus.spi_clk = cpol;
            repeat (half) @(negedge sys_clk);
        end
        bus.spi_csn = 1'b1;
        repeat (12) @(negedge sys_clk);
    endtask

    function automatic logic [DATA_W-1:0] rx_at(input int idx);
        if (rx_q.size() > idx) return rx_q[idx];
        return 'x;
    endfunction

    task automatic test_reset();
        bus.spi_csn  = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_mode = SPI_MODE0;
        new_tx(16'h0000, 16'h0000, 16'h0000);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_tests += 6;
        if (bus.tx_load !== 1'b0) begin n_fail++; $display("FAIL rst_tx_load got %b want 0", bus.tx_load); end
        if (bus.rx_data !== '0) begin n_fail++; $display("FAIL rst_rx_data got %h want 0", bus.rx_data); end
        if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid got %b want 0", bus.rx_valid); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso got %b want 0", bus.spi_miso); end
        if (bus.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", bus.spi_miso_oe); end
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.spi_miso_oe !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_idle busy=%b oe=%b want 0/0", bus.busy, bus.spi_miso_oe);
        end
    endtask

    task automatic test_mode0();
        logic [63:0] miso;
        int rb = rx_q.size();
        new_tx(16'h3C96, 16'h0000, 16'h0000);
        xfer(SPI_MODE0, SPI_MODE0, 16, 5, 64'hA55A, miso);
        n_tests += 3;
        if (rx_q.size() != rb + 1) begin n_fail++; $display("FAIL m0_rx_count got %0d want %0d", rx_q.size() - rb, 1); end
        if (rx_at(rb) !== 16'hA55A) begin n_fail++; $display("FAIL m0_rx_data got %h want a55a", rx_at(rb)); end
        if (miso[15:0] !== 16'h3C96) begin n_fail++; $display("FAIL m0_miso got %h want 3c96", miso[15:0]); end
    endtask

    task automatic test_mode3();
        logic [63:0] miso;
        int rb = rx_q.size();
        int oe0;
        new_tx(16'hFFFE, 16'h0000, 16'h0000);
        n_tests++;
        if (bus.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL m3_oe_before got %b want 0", bus.spi_miso_oe); end
        oe0 = n_oe;
        xfer(SPI_MODE3, SPI_MODE3, 16, 6, 64'h8001, miso);
        n_tests += 5;
        if (rx_at(rb) !== 16'h8001) begin n_fail++; $display("FAIL m3_rx_data got %h want 8001", rx_at(rb)); end
        if (miso[15:0] !== 16'hFFFE) begin n_fail++; $display("FAIL m3_miso got %h want fffe", miso[15:0]); end
        if (n_oe <= oe0) begin n_fail++; $display("FAIL m3_oe_during got %0d cycles want >0", n_oe - oe0); end
        if (bus.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL m3_oe_after got %b want 0", bus.spi_miso_oe); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL m3_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] miso;
        int rb = rx_q.size();
        int ld0 = n_tx_load;
        new_tx(16'hC3A5, 16'hBEEF, 16'h0000);
        ld0 = n_tx_load;
        xfer(SPI_MODE0, SPI_MODE0, 32, 5, 64'h1234_5678, miso);
        n_tests += 6;
        if (rx_q.size() != rb + 2) begin n_fail++; $display("FAIL b2b_rx_count got %0d want 2", rx_q.size() - rb); end
        if (rx_at(rb) !== 16'h1234) begin n_fail++; $display("FAIL b2b_rx0 got %h want 1234", rx_at(rb)); end
        if (rx_at(rb + 1) !== 16'h5678) begin n_fail++; $display("FAIL b2b_rx1 got %h want 5678", rx_at(rb + 1)); end
        if (n_tx_load - ld0 < 2) begin n_fail++; $display("FAIL b2b_tx_load got %0d want >=2", n_tx_load - ld0); end
        if (miso[31:16] !== 16'hC3A5) begin n_fail++; $display("FAIL b2b_miso0 got %h want c3a5", miso[31:16]); end
        if (miso[15:0] !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_miso1 got %h want beef", miso[15:0]); end
    endtask

    task automatic test_abort();
        logic [63:0] miso;
        logic [DATA_W-1:0] rd;
        int rb = rx_q.size();
        int fe0 = n_ferr;
`ifdef SPI_SLAVE_ERR_EN
        logic [7:0] ec0;
        ec0 = bus.err_cnt;
`endif
        rd = bus.rx_data;
        new_tx(DATA_W'($urandom), 16'h0000, 16'h0000);
        xfer(SPI_MODE0, SPI_MODE0, 9, 5, 64'($urandom_range(0, 511)), miso);
        n_tests += 2;
        if (rx_q.size() != rb) begin n_fail++; $display("FAIL abort_rx_count got %0d want 0", rx_q.size() - rb); end
        if (bus.rx_data !== rd) begin n_fail++; $display("FAIL abort_rx_data got %h want %h", bus.rx_data, rd); end
`ifdef SPI_SLAVE_ERR_EN
        n_tests += 2;
        if (n_ferr != fe0 + 1) begin n_fail++; $display("FAIL abort_frame_err got %0d want 1", n_ferr - fe0); end
        if (bus.err_cnt !== ec0 + 8'd1) begin n_fail++; $display("FAIL abort_err_cnt got %0d want %0d", bus.err_cnt, ec0 + 8'd1); end
`else
        if (fe0 != n_ferr) $display("unexpected frame_err count");
`endif
    endtask

    task automatic test_mode_change();
        logic [63:0] miso;
        logic [DATA_W-1:0] d0, d1, t0, t1;
        int rb = rx_q.size();
        d0 = DATA_W'($urandom); d1 = DATA_W'($urandom);
        t0 = DATA_W'($urandom); t1 = DATA_W'($urandom);
        new_tx(t0, 16'h0000, 16'h0000);
        xfer(SPI_MODE0, SPI_MODE1, 16, 5, 64'(d0), miso);
        n_tests += 2;
        if (rx_at(rb) !== d0) begin n_fail++; $display("FAIL mchg_rx0 got %h want %h", rx_at(rb), d0); end
        if (miso[15:0] !== t0) begin n_fail++; $display("FAIL mchg_miso0 got %h want %h", miso[15:0], t0); end
        new_tx(t1, 16'h0000, 16'h0000);
        xfer(SPI_MODE1, SPI_MODE1, 16, 5, 64'(d1), miso);
        n_tests += 2;
        if (rx_at(rb + 1) !== d1) begin n_fail++; $display("FAIL mchg_rx1 got %h want %h", rx_at(rb + 1), d1); end
        if (miso[15:0] !== t1) begin n_fail++; $display("FAIL mchg_miso1 got %h want %h", miso[15:0], t1); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] miso;
        logic [DATA_W-1:0] t0;
        int rb;
        new_tx(16'h5A5A, 16'h0000, 16'h0000);
        bus.spi_mode = SPI_MODE0;
        bus.spi_clk  = 1'b0;
        repeat (8) @(negedge sys_clk);
        bus.spi_csn  = 1'b0;
        bus.spi_mosi = 1'b1;
        repeat (10) @(negedge sys_clk);
        for (int i = 0; i < 5; i++) begin
            bus.spi_clk = 1'b1; repeat (5) @(negedge sys_clk);
            bus.spi_clk = 1'b0; bus.spi_mosi = ~bus.spi_mosi; repeat (5) @(negedge sys_clk);
        end
        sys_rst = 1'b1;
        #1;
        n_tests += 5;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        if (bus.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_oe got %b want 0", bus.spi_miso_oe); end
        if (bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL rmid_miso got %b want 0", bus.spi_miso); end
        if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rx_valid got %b want 0", bus.rx_valid); end
        if (bus.rx_data !== '0) begin n_fail++; $display("FAIL rmid_rx_data got %h want 0", bus.rx_data); end
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        rb = rx_q.size();
        for (int i = 0; i < 20; i++) begin
            bus.spi_clk = 1'b1; repeat (5) @(negedge sys_clk);
            bus.spi_clk = 1'b0; repeat (5) @(negedge sys_clk);
        end
        n_tests += 2;
        if (rx_q.size() != rb) begin n_fail++; $display("FAIL rmid_no_rx got %0d want 0", rx_q.size() - rb); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_stay_idle busy=%b want 0", bus.busy); end
        bus.spi_csn = 1'b1;
        repeat (12) @(negedge sys_clk);
        t0 = DATA_W'($urandom);
        new_tx(t0, 16'h0000, 16'h0000);
        rb = rx_q.size();
        xfer(SPI_MODE0, SPI_MODE0, 16, 5, 64'h00FF, miso);
        n_tests += 2;
        if (rx_at(rb) !== 16'h00FF) begin n_fail++; $display("FAIL rmid_rx got %h want 00ff", rx_at(rb)); end
        if (miso[15:0] !== t0) begin n_fail++; $display("FAIL rmid_miso got %h want %h", miso[15:0], t0); end
    endtask

    task automatic test_random();
        logic [63:0] miso, mosi, exp_miso;
        logic [DATA_W-1:0] d [2];
        logic [DATA_W-1:0] t [3];
        logic [1:0] mode;
        int half, nw, rb;
        for (int it = 0; it < 8; it++) begin
            mode = 2'($urandom_range(0, 3));
            half = $urandom_range(5, 8);
            nw   = $urandom_range(1, 2);
            for (int j = 0; j < 2; j++) d[j] = DATA_W'($urandom);
            for (int j = 0; j < 3; j++) t[j] = DATA_W'($urandom);
            mosi = '0; exp_miso = '0;
            for (int j = 0; j < nw; j++) begin
                mosi     = (mosi << DATA_W) | 64'(d[j]);
                exp_miso = (exp_miso << DATA_W) | 64'(t[j]);
            end
            new_tx(t[0], t[1], t[2]);
            rb = rx_q.size();
            xfer(mode, mode, nw * DATA_W, half, mosi, miso);
            n_tests += 2 + nw;
            if (rx_q.size() != rb + nw) begin n_fail++; $display("FAIL rnd%0d_rx_count got %0d want %0d", it, rx_q.size() - rb, nw); end
            for (int j = 0; j < nw; j++)
                if (rx_at(rb + j) !== d[j]) begin n_fail++; $display("FAIL rnd%0d_rx%0d mode %0d got %h want %h", it, j, mode, rx_at(rb + j), d[j]); end
            if (miso !== exp_miso) begin n_fail++; $display("FAIL rnd%0d_miso mode %0d got %h want %h", it, mode, miso, exp_miso); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_abort();
        test_mode_change();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the same serial interface driven by spi_master: csn / clk / mosi in, miso out. It is the far-end counterpart used for loopback boards and FPGA-to-FPGA links.
- Oversamples all SPI pins in the sys_clk domain. Supports SPI modes 0-3, MSB first, fixed word length.
- Delivers each received word with a one-cycle valid strobe. Shifts out a user-supplied transmit word on the same frame.

Parameters:
- DATA_W, 16, word length in bits; equals the spi_master word (spi_sdata/spi_rdata width).
- SYNC_STG, 2, synchronizer flops per SPI input (min 2).

Ports:
- sys_clk  in  1  system clock, 50 MHz; must be >= 8x SCK frequency.
- sys_rst  in  1  asynchronous reset, active-high.
- spi_mode  in  2  [1]=CPOL, [0]=CPHA; captured at frame start.
- tx_data  in  DATA_W  word to transmit; sampled on tx_load.
- tx_load  out  1  one-cycle pulse when tx_data is sampled.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse, rx_data updated same cycle.
- busy  out  1  high while a frame is active (csn low, synchronized).
- spi_csn  in  1  chip select, active-low, asynchronous to sys_clk.
- spi_clk  in  1  SCK from master.
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  output enable for the top-level tristate; high only while busy.

Behaviour:
- Reset (async, sys_rst=1): tx_load=0, rx_data=0, rx_valid=0, busy=0, spi_miso=0, spi_miso_oe=0. The FSM enters IDLE, the bit counter is 0, and all synchronizers are set to 1 (csn idle).
- Input sampling:
  - csn, clk and mosi each pass through SYNC_STG flops.
  - Edges are detected against one extra delayed copy.
  - Pin-to-internal-event latency is SYNC_STG+1 sys_clk cycles.
- Edge naming:
  - Leading edge = SCK leaving CPOL level; trailing edge = returning to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. The opposite edge is the shift edge.
- FSM has 3 states:
  - IDLE: busy=0, oe=0. On synchronized csn falling edge: latch spi_mode into mode_r, pulse tx_load, load shift_tx <= tx_data, cnt <= 0, go to LOAD.
  - LOAD (1 cycle): busy=1, oe=1. If mode_r CPHA=0, drive spi_miso=shift_tx[MSB] now. If CPHA=1, spi_miso keeps its value until the first leading edge. Go to ACTIVE.
  - ACTIVE:
    - On sample edge: shift_rx <= {shift_rx[DATA_W-2:0], mosi_s}; cnt <= cnt+1.
    - When cnt==DATA_W-1 on a sample edge: rx_data <= completed word, rx_valid=1 next cycle, cnt wraps to 0, tx_load pulses, shift_tx <= tx_data (back-to-back words inside one csn frame).
    - On shift edge (CPHA=0): drive the next tx bit. Exception: the trailing edge that closes a word drives the MSB of the newly loaded word.
    - On shift edge (CPHA=1): every leading edge drives the next bit, including the MSB of each word.
    - On csn rising edge: go to IDLE. A partial word (cnt!=0) is discarded; rx_valid does not fire.
- mode_r is frozen for the whole frame; changes on spi_mode while busy are ignored.
- Simultaneous csn rise and sample edge in the same cycle: csn wins; the sample is dropped.
- The bit counter is $clog2(DATA_W) wide and wraps modulo DATA_W.
- A csn glitch shorter than SYNC_STG cycles is not guaranteed to be seen. If it is seen, it is treated as a full frame end/start.
- Reset asserted mid-frame aborts immediately with no rx_valid. After reset release the block waits in IDLE for the next csn falling edge, even if csn is still low.

Optional Feature:
- Macro SPI_SLAVE_ERR_EN.
- When defined, adds two ports:
  - frame_err out 1: one-cycle pulse when csn rises while cnt!=0.
  - err_cnt out 8: count of frame_err events, saturating at 8'hFF, reset 0.
- When undefined, neither port exists and partial words are silently discarded.

Decomposition:
- Shared package spi_pkg: mode encoding constants (SPI_MODE0..3), CPOL/CPHA bit indices, state encoding (ST_IDLE/ST_LOAD/ST_ACTIVE), default DATA_W.
- One natural sub-module, spi_sync_edge: a SYNC_STG-deep synchronizer with rise/fall pulse outputs, instantiated three times (csn, clk, mosi; the mosi instance uses only the level output).

Test Plan:
- Mode 0, SCK = sys_clk/10, master sends 16'hA55A, tx_data=16'h3C96 -> one rx_valid with rx_data=16'hA55A; miso bit stream 0011_1100_1001_0110 sampled on rising SCK.
- Mode 3 (CPOL=1, CPHA=1), master sends 16'h8001, tx_data=16'hFFFE -> rx_data=16'h8001; master captures 16'hFFFE; oe low before csn fall and after csn rise.
- One csn frame of 32 SCK cycles carrying 16'h1234 then 16'h5678, tx_data changed to 16'hBEEF after the first tx_load -> two rx_valid pulses (16'h1234, 16'h5678); tx_load pulses twice; second tx word is 16'hBEEF.
- Frame aborted after 9 bits -> no rx_valid, rx_data unchanged; with SPI_SLAVE_ERR_EN, frame_err pulses once and err_cnt goes 0->1.
- spi_mode changed from 0 to 1 mid-frame -> current word still decoded as mode 0; the next frame uses mode 1.
- sys_rst pulsed after 5 bits of a frame, csn held low -> all outputs at reset values; no rx_valid until a new csn fall/rise cycle; next full frame 16'h00FF is received correctly.
